// File: rtl/uart_tx_scheduler_pkg.sv
// Shared calculator package: scheduler state encoding, ASCII constants
// and the helper that selects a byte of the result message.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Position of a byte inside the result message.
  localparam logic [1:0] RES_IDX_TENS  = 2'd0;
  localparam logic [1:0] RES_IDX_UNITS = 2'd1;
  localparam logic [1:0] RES_IDX_CR    = 2'd2;
  localparam logic [1:0] RES_IDX_LF    = 2'd3;

  // Byte of the result message at position idx.
  function automatic logic [7:0] res_byte(input logic [1:0] idx,
                                          input logic [7:0] tens,
                                          input logic [7:0] units);
    logic [7:0] b;
    case (idx)
      RES_IDX_TENS:  b = tens;
      RES_IDX_UNITS: b = units;
      RES_IDX_CR:    b = ASCII_CR;
      default:       b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// sync_byte_fifo: small synchronous byte FIFO for echo traffic. The head
// byte is visible combinationally so the scheduler can launch it in the
// same cycle it pops it. A write and a read in the same cycle both
// succeed even when full; a write into a full FIFO without a read drops.
module sync_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_rd_ok   = i_rd && !w_empty;
  assign w_wr_ok   = i_wr && (!w_full || w_rd_ok);
  assign o_drop    = i_wr && !w_wr_ok;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array, no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one byte transmitter between an echo stream
// and calculator result messages (tens, units, optional CR LF). Grants
// alternate round-robin; a result message is sent without interleaving.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int ECHO_DEPTH = 4,
  parameter bit CRLF_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  input  logic       res_req,
  input  logic [7:0] res_tens,
  input  logic [7:0] res_units,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       echo_full,
  output logic       res_pending,
  output logic       overflow
);

  localparam logic [1:0] LAST_IDX = CRLF_EN ? RES_IDX_LF : RES_IDX_UNITS;

  sched_state_t r_state;
  sched_state_t w_state_next;

  logic       r_grant_res;   // current grant belongs to the result message
  logic       r_last_res;    // last grant went to the result source
  logic [1:0] r_res_idx;
  logic [7:0] r_tens;
  logic [7:0] r_units;
  logic       r_res_pending;
  logic       r_overflow;
  logic [7:0] r_tx_hold;

  logic       w_fifo_rd;
  logic [7:0] w_fifo_data;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_fifo_drop;
  logic       w_idle_grant;
  logic       w_grant_res_sel;
  logic       w_res_more;
  logic       w_done;
  logic [7:0] w_load_byte;

  sync_byte_fifo #(.DEPTH(ECHO_DEPTH)) u_echo_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (echo_valid),
    .i_wr_data (echo_data),
    .i_rd      (w_fifo_rd),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_drop    (w_fifo_drop)
  );

  // Result wins a tie only if echo was granted last; a lone source always wins.
  assign w_grant_res_sel = r_res_pending && (w_fifo_empty || !r_last_res);
  assign w_idle_grant    = (r_state == ST_IDLE) && !tx_busy &&
                           (!w_fifo_empty || r_res_pending);
  assign w_res_more      = r_grant_res && (r_res_idx != LAST_IDX);
  assign w_done          = (r_state == ST_WAIT_DONE) && !tx_busy;
  assign w_load_byte     = r_grant_res ? res_byte(r_res_idx, r_tens, r_units)
                                       : w_fifo_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; a result grant loops through LOAD until its last byte.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_idle_grant) w_state_next = ST_LOAD;
      ST_LOAD:      w_state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tx_busy) w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) w_state_next = w_res_more ? ST_LOAD : ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: launch pulse and FIFO pop in LOAD; tx_data holds between launches.
  always_comb begin
    tx_start  = 1'b0;
    w_fifo_rd = 1'b0;
    tx_data   = r_tx_hold;
    if (r_state == ST_LOAD) begin
      tx_start  = 1'b1;
      w_fifo_rd = !r_grant_res;
      tx_data   = w_load_byte;
    end
  end

  // Grant bookkeeping and result byte index (tens skipped when it is '0').
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_res <= 1'b0;
      r_last_res  <= 1'b1;
      r_res_idx   <= RES_IDX_TENS;
    end else if (w_idle_grant) begin
      r_grant_res <= w_grant_res_sel;
      r_last_res  <= w_grant_res_sel;
      if (w_grant_res_sel)
        r_res_idx <= (r_tens == ASCII_ZERO) ? RES_IDX_UNITS : RES_IDX_TENS;
    end else if (w_done && w_res_more) begin
      r_res_idx <= r_res_idx + 2'd1;
    end
  end

  // Result snapshot; held until the last byte's transmission completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_pending <= 1'b0;
      r_tens        <= 8'h00;
      r_units       <= 8'h00;
    end else if (res_req && !r_res_pending) begin
      r_res_pending <= 1'b1;
      r_tens        <= res_tens;
      r_units       <= res_units;
    end else if (w_done && r_grant_res && !w_res_more) begin
      r_res_pending <= 1'b0;
    end
  end

  // Sticky overflow on a dropped echo byte or an ignored result request.
  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else if (w_fifo_drop || (res_req && r_res_pending)) r_overflow <= 1'b1;
  end

  // Keep the launched byte on tx_data until the next launch.
  always_ff @(posedge clk) begin
    if (rst) r_tx_hold <= 8'h00;
    else if (r_state == ST_LOAD) r_tx_hold <= w_load_byte;
  end

  assign echo_full   = w_fifo_full;
  assign res_pending = r_res_pending;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a scoreboard of expected bytes
// and a byte-transmitter model that stays busy BUSY_CYC cycles per byte.
module tb_uart_tx_scheduler;

  localparam int BUSY_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       echo_valid = 1'b0;
  logic [7:0] echo_data = 8'h00;
  logic       res_req = 1'b0;
  logic [7:0] res_tens = 8'h00;
  logic [7:0] res_units = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       echo_full;
  logic       res_pending;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int  busy_cnt = 0;
  bit  stuck = 1'b0;
  bit  prev_start = 1'b0;
  bit  arm = 1'b0;
  int  neg_cnt = 0;
  int  strobe_neg = 0;
  int  first_start_neg = 0;

  uart_tx_scheduler #(.ECHO_DEPTH(4), .CRLF_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .echo_valid  (echo_valid),
    .echo_data   (echo_data),
    .res_req     (res_req),
    .res_tens    (res_tens),
    .res_units   (res_units),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .echo_full   (echo_full),
    .res_pending (res_pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model and scoreboard: every launch is checked on the falling edge.
  always @(negedge clk) begin
    neg_cnt++;
    if (tx_start) begin
      check("tx_start_one_cycle", {31'b0, prev_start}, 32'h0);
      check("tx_start_expected", {31'b0, (exp_q.size() != 0)}, 32'h1);
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data", {24'b0, tx_data}, {24'b0, e});
        $display("[TB] tx byte %02h (expected %02h)", tx_data, e);
      end
      if (arm) begin
        first_start_neg = neg_cnt;
        arm = 1'b0;
      end
      busy_cnt = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = stuck || (busy_cnt > 0);
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_tx_start", {31'b0, tx_start}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_echo_full", {31'b0, echo_full}, 32'h0);
    check("rst_res_pending", {31'b0, res_pending}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_busy || res_pending) && k < 400) begin
      tick();
      k++;
    end
    check(tag, {31'b0, (k < 400)}, 32'h1);
    repeat (3) tick();
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_start && k < 50);
    check(tag, {31'b0, tx_start}, 32'h1);
  endtask

  task automatic push_result(input logic [7:0] t, input logic [7:0] u);
    if (t != 8'h30) exp_q.push_back(t);
    exp_q.push_back(u);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();

    // Result 1,2 with CR LF; check launch latency and pending flag.
    res_req = 1'b1; res_tens = 8'h31; res_units = 8'h32;
    push_result(8'h31, 8'h32);
    strobe_neg = neg_cnt + 1; arm = 1'b1;
    tick();
    res_req = 1'b0;
    check("res_pending_set", {31'b0, res_pending}, 32'h1);
    drain("drain_res12");
    check("latency_res", first_start_neg - strobe_neg, 32'd2);
    check("res_pending_clear", {31'b0, res_pending}, 32'h0);
    check("tx_data_held", {24'b0, tx_data}, 32'h0A);
    check("no_overflow", {31'b0, overflow}, 32'h0);

    // Leading '0' tens digit is skipped.
    res_req = 1'b1; res_tens = 8'h30; res_units = 8'h37;
    push_result(8'h30, 8'h37);
    tick();
    res_req = 1'b0;
    drain("drain_res07");

    // Echo 'a' plus result in one cycle, then 'b': round-robin and atomic message.
    echo_valid = 1'b1; echo_data = 8'h61;
    res_req = 1'b1; res_tens = 8'h31; res_units = 8'h32;
    exp_q.push_back(8'h61);
    push_result(8'h31, 8'h32);
    exp_q.push_back(8'h62);
    strobe_neg = neg_cnt + 1; arm = 1'b1;
    tick();
    res_req = 1'b0; echo_data = 8'h62;
    tick();
    echo_valid = 1'b0;
    drain("drain_mixed");
    check("latency_echo", first_start_neg - strobe_neg, 32'd2);
    check("mixed_no_overflow", {31'b0, overflow}, 32'h0);

    // Second request while pending is ignored and flags overflow.
    res_req = 1'b1; res_tens = 8'h34; res_units = 8'h35;
    push_result(8'h34, 8'h35);
    tick();
    res_req = 1'b0;
    repeat (3) tick();
    res_req = 1'b1; res_tens = 8'h39; res_units = 8'h39;
    tick();
    res_req = 1'b0;
    check("dup_req_overflow", {31'b0, overflow}, 32'h1);
    drain("drain_dup");
    do_reset();

    // FIFO overflow with transmitter stuck busy, then write+read while full.
    stuck = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      echo_valid = 1'b1; echo_data = 8'h41 + 8'(i);
      tick();
    end
    echo_valid = 1'b0;
    check("fifo_full", {31'b0, echo_full}, 32'h1);
    check("fifo_overflow", {31'b0, overflow}, 32'h1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h41 + 8'(i));
    stuck = 1'b0;
    wait_start("full_first_launch");
    echo_valid = 1'b1; echo_data = 8'h47;
    exp_q.push_back(8'h47);
    tick();
    echo_valid = 1'b0;
    check("full_rw_count_kept", {31'b0, echo_full}, 32'h1);
    drain("drain_fifo");
    check("fifo_not_full", {31'b0, echo_full}, 32'h0);
    do_reset();

    // Reset in WAIT_DONE of the units byte aborts the message.
    res_req = 1'b1; res_tens = 8'h31; res_units = 8'h32;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    tick();
    res_req = 1'b0;
    wait_start("abort_tens_launch");
    wait_start("abort_units_launch");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx_start", {31'b0, tx_start}, 32'h0);
    check("abort_tx_data", {24'b0, tx_data}, 32'h0);
    check("abort_res_pending", {31'b0, res_pending}, 32'h0);
    check("abort_echo_full", {31'b0, echo_full}, 32'h0);
    check("abort_overflow", {31'b0, overflow}, 32'h0);
    repeat (40) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
